// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode for the load/store unit.
// Used by load_store_unit and lsu_lane_unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte-lane datapath: load extract/extend and sub-word store merge.
// Purely combinational.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [63:0] rbuf,
    input  logic [63:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    output logic [63:0] load_data,
    output logic [63:0] merge_data
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] mask;

    assign shamt = {offset, 3'b000};
    assign lane  = rbuf >> shamt;

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{56{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{48{lane[15]}}, lane[15:0]};
            F3_W:    load_data = {{32{lane[31]}}, lane[31:0]};
            F3_D:    load_data = lane;
            F3_BU:   load_data = {56'd0, lane[7:0]};
            F3_HU:   load_data = {48'd0, lane[15:0]};
            F3_WU:   load_data = {32'd0, lane[31:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        mask = '1;
        case (funct3[1:0])
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = '1;
        endcase
    end

    assign merge_data = (rbuf & ~(mask << shamt))
                      | ((wdata & mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// Load/store FSM between execute and a 64-bit data memory.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] DataAdr,
    output logic [63:0] WriteAddr,
    output logic [63:0] WriteData,
    input  logic [63:0] MemOut
);

    lsu_state_t  state, state_n;
    logic        write_q;
    logic        err_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rbuf;

    logic        bad_funct3;
    logic        out_of_range;
    logic        misaligned;
    logic        req_err;
    logic        req_sd;
    logic [2:0]  offset;
    logic [63:0] load_data;
    logic [63:0] merge_data;

    assign bad_funct3 = req_write ? req_funct3[2]
                                  : (req_funct3 == 3'b111);
    assign out_of_range = req_addr[63:3] >= 61'(MEM_WORDS);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned =
        |(req_addr[2:0] & 3'(size_bytes(req_funct3) - 4'd1));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = bad_funct3 | out_of_range | misaligned;
    assign req_sd  = req_write & (req_funct3 == F3_D);

    // Round the lane down to natural alignment; no-op when checked.
    assign offset = addr_q[2:0]
                  & ~3'(size_bytes(funct3_q) - 4'd1);

    lsu_lane_unit u_lane (
        .rbuf       (rbuf),
        .wdata      (wdata_q),
        .funct3     (funct3_q),
        .offset     (offset),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                write_q  <= req_write;
                err_q    <= req_err;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state == READ) begin
                rbuf <= MemOut;
            end
        end
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)     state_n = RESP;
                    else if (req_sd) state_n = WRITE;
                    else             state_n = READ;
                end
            end
            READ: begin
                MemRead = 1'b1;
                state_n = write_q ? WRITE : RESP;
            end
            WRITE: begin
                MemWrite = 1'b1;
                state_n  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!write_q && !err_q) resp_rdata = load_data;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign DataAdr   = {addr_q[63:3], 3'b000};
    assign WriteAddr = {addr_q[63:3], 3'b000};
    assign WriteData = (funct3_q == F3_D) ? wdata_q : merge_data;

endmodule
